// File: rtl/prog_loader_if.sv
// ---------------------------------------------------------------------------
// prog_loader_if -- byte stream and RAM write bus of the program loader.
//
// Byte stream (upstream -> loader):
//   byte_valid   upstream byte present
//   byte_data    upstream byte
//   byte_ready   loader accepts a byte this cycle
// RAM write port (loader -> 256x16 program/data RAM):
//   C12          RAM write enable
//   address      RAM word address
//   wr_data      RAM write data
//
// Modports:
//   master  environment side; drives the byte stream and observes the RAM port
//   slave   loader side
// ---------------------------------------------------------------------------
interface prog_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        C12;
  logic [7:0]  address;
  logic [15:0] wr_data;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, C12, address, wr_data
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, C12, address, wr_data
  );
endinterface

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader -- loads a byte stream into a 256x16 program/data RAM while
// holding the CPU off the RAM port.
//
// Stream format: start address, word count N (0 means 256), then N words,
// high byte first. Each complete word is written in a one-cycle WRITE state.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous, active-high reset
//   start     one-cycle pulse that begins a session (honoured only in IDLE)
//   abort     ends the session without a done pulse (ignored in IDLE)
//   bus       byte stream + RAM write port (prog_loader_if.slave)
//   cpu_hold  high while a session is active
//   done      one-cycle pulse on successful completion
//   err       sticky timeout flag, cleared by rst or an accepted start
//
// Parameter:
//   TIMEOUT   cycles without a byte in a receive state before aborting
// ---------------------------------------------------------------------------
module prog_loader #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  prog_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_CNT,
    GET_HI,
    GET_LO,
    WRITE,
    DONE
  } state_t;

  state_t      state;
  logic [7:0]  ptr;        // address of the next word to write
  logic [7:0]  hi;         // high byte of the word being assembled
  logic [8:0]  remaining;  // words still to write; 9 bits so a count of 256 fits
  logic [15:0] to_cnt;     // cycles spent in a receive state without a byte
  logic        rx_state;
  logic        xfer;

  assign rx_state = (state == GET_ADDR) || (state == GET_CNT) ||
                    (state == GET_HI)   || (state == GET_LO);
  assign xfer     = rx_state && bus.byte_valid;

  // Status outputs are pure decodes of the state register, so they are
  // stable for the whole cycle and change only after a rising edge.
  assign bus.byte_ready = rx_state;
  assign bus.C12        = (state == WRITE);
  assign cpu_hold       = (state != IDLE);
  assign done           = (state == DONE);

  // NOTE: every register here is assigned with <= so all of them update
  // together from the values present before the edge; a blocking = would let
  // later statements see already-updated values and change the behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 8'h00;
      hi          <= 8'h00;
      remaining   <= 9'd0;
      to_cnt      <= 16'd0;
      bus.address <= 8'h00;
      bus.wr_data <= 16'h0000;
      err         <= 1'b0;
    end else if (state == IDLE) begin
      // start outranks a simultaneous abort because abort means nothing here.
      if (start) begin
        state  <= GET_ADDR;
        err    <= 1'b0;
        to_cnt <= 16'd0;
      end
    end else if (abort) begin
      // A write in progress has already been presented for its full cycle,
      // so leaving WRITE on abort never truncates it.
      state <= IDLE;
    end else if (rx_state && !xfer && (to_cnt == TIMEOUT - 16'd1)) begin
      // This idle cycle brings the count up to TIMEOUT.
      state <= IDLE;
      err   <= 1'b1;
    end else begin
      if (rx_state) begin
        to_cnt <= xfer ? 16'd0 : to_cnt + 16'd1;
      end

      case (state)
        GET_ADDR: begin
          if (xfer) begin
            ptr   <= bus.byte_data;
            state <= GET_CNT;
          end
        end

        GET_CNT: begin
          if (xfer) begin
            remaining <= (bus.byte_data == 8'h00) ? 9'd256 : {1'b0, bus.byte_data};
            state     <= GET_HI;
          end
        end

        GET_HI: begin
          if (xfer) begin
            hi    <= bus.byte_data;
            state <= GET_LO;
          end
        end

        GET_LO: begin
          // The RAM port registers are loaded here so they are already stable
          // for the whole WRITE cycle and simply hold afterwards.
          if (xfer) begin
            bus.address <= ptr;
            bus.wr_data <= {hi, bus.byte_data};
            state       <= WRITE;
          end
        end

        WRITE: begin
          ptr       <= ptr + 8'd1;
          remaining <= remaining - 9'd1;
          to_cnt    <= 16'd0;
          state     <= (remaining == 9'd1) ? DONE : GET_HI;
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader -- scoreboard bench for prog_loader.
// Stimulus tasks push the expected RAM writes and done pulse into a queue;
// an independent monitor pops and compares whenever the DUT writes or
// signals done.
// ---------------------------------------------------------------------------
module tb_prog_loader;

  logic clk;
  logic rst;
  logic start;
  logic abort;
  logic cpu_hold;
  logic done;
  logic err;

  prog_loader_if bus ();

  prog_loader #(.TIMEOUT(16'd16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [7:0]  a;
    logic [15:0] d;
  } exp_t;

  exp_t        q[$];
  logic [15:0] words[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          last_wr = -10;
  int          gmax  = 0;
  exp_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: compares every DUT write and done pulse against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.C12) begin
        if (q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          mon_e = q.pop_front();
          check("write_kind", {31'd0, mon_e.is_done}, 0);
          check("write_addr", {24'd0, bus.address}, {24'd0, mon_e.a});
          check("write_data", {16'd0, bus.wr_data}, {16'd0, mon_e.d});
          check("write_hold", {31'd0, cpu_hold}, 1);
          last_wr = cyc;
        end
      end
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          mon_e = q.pop_front();
          check("done_kind", {31'd0, mon_e.is_done}, 1);
          check("done_timing", cyc, last_wr + 1);
          check("done_hold", {31'd0, cpu_hold}, 1);
        end
      end
    end
  end

  // Caller is at a negedge; returns at a negedge once the byte is taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int i = 0; i < 40 && !bus.byte_ready; i++) @(negedge clk);
    if (!bus.byte_ready) check("byte_accept_timeout", 0, 1);
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    check({tag, "_drained"}, q.size(), 0);
    q.delete();
    @(negedge clk);
    check({tag, "_idle_hold"}, {31'd0, cpu_hold}, 0);
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [15:0] d);
    q.push_back('{is_done: 1'b0, a: a, d: d});
  endtask

  task automatic push_done();
    q.push_back('{is_done: 1'b1, a: 8'h00, d: 16'h0000});
  endtask

  function automatic int gap();
    return (gmax == 0) ? 0 : int'($urandom_range(0, gmax));
  endfunction

  // Full session from the words queue; expected addresses wrap modulo 256.
  task automatic run_session(input logic [7:0] a, input logic [7:0] n, input string tag);
    logic [7:0] ea;
    pulse_start();
    check({tag, "_start_hold"}, {31'd0, cpu_hold}, 1);
    ea = a;
    foreach (words[i]) begin
      push_wr(ea, words[i]);
      ea = ea + 8'd1;
    end
    push_done();
    send_byte(a, gap());
    send_byte(n, gap());
    foreach (words[i]) begin
      send_byte(words[i][15:8], gap());
      send_byte(words[i][7:0], gap());
    end
    wait_drain(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    start          = 1'b0;
    abort          = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_c12",      {31'd0, bus.C12}, 0);
    check("rst_hold",     {31'd0, cpu_hold}, 0);
    check("rst_done",     {31'd0, done}, 0);
    check("rst_err",      {31'd0, err}, 0);
    check("rst_ready",    {31'd0, bus.byte_ready}, 0);
    check("rst_address",  {24'd0, bus.address}, 0);
    check("rst_wr_data",  {16'd0, bus.wr_data}, 0);
    rst = 1'b0;

    // Two words at A0, with a stray start mid-session that must be ignored.
    push_wr(8'hA0, 16'h0013);
    push_wr(8'hA1, 16'hFFF3);
    push_done();
    pulse_start();
    check("basic_start_hold", {31'd0, cpu_hold}, 1);
    check("basic_start_err",  {31'd0, err}, 0);
    send_byte(8'hA0, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    pulse_start();
    send_byte(8'h13, 0);
    send_byte(8'hFF, 0);
    send_byte(8'hF3, 0);
    wait_drain("basic");
    check("basic_addr_held", {24'd0, bus.address}, 32'hA1);
    check("basic_data_held", {16'd0, bus.wr_data}, 32'hFFF3);

    // Pointer wrap from FF to 00.
    words = '{16'h1234, 16'h5678};
    run_session(8'hFF, 8'h02, "wrap");

    // Timeout after the high byte: no write, err set, next start clears err.
    pulse_start();
    send_byte(8'h30, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAB, 0);
    repeat (20) @(negedge clk);
    check("timeout_hold",  {31'd0, cpu_hold}, 0);
    check("timeout_err",   {31'd0, err}, 1);
    check("timeout_ready", {31'd0, bus.byte_ready}, 0);
    pulse_start();
    check("restart_err",  {31'd0, err}, 0);
    check("restart_hold", {31'd0, cpu_hold}, 1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_addr_hold", {31'd0, cpu_hold}, 0);
    check("abort_addr_err",  {31'd0, err}, 0);

    // Abort in GET_LO while the low byte is offered: abort wins, no write.
    pulse_start();
    send_byte(8'h40, 0);
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h22;
    abort          = 1'b1;
    @(negedge clk);
    abort          = 1'b0;
    bus.byte_valid = 1'b0;
    check("abort_lo_hold", {31'd0, cpu_hold}, 0);
    check("abort_lo_done", {31'd0, done}, 0);
    repeat (3) @(negedge clk);

    // Reset asserted in GET_HI with a byte pending.
    pulse_start();
    send_byte(8'h50, 0);
    send_byte(8'h03, 0);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h77;
    #2 rst = 1'b1;
    #1;
    check("rst_mid_hold",    {31'd0, cpu_hold}, 0);
    check("rst_mid_ready",   {31'd0, bus.byte_ready}, 0);
    check("rst_mid_address", {24'd0, bus.address}, 0);
    check("rst_mid_wr_data", {16'd0, bus.wr_data}, 0);
    repeat (2) @(negedge clk);
    bus.byte_valid = 1'b0;
    rst = 1'b0;

    // start and abort together in IDLE: start wins.
    push_wr(8'h05, 16'hBEEF);
    push_done();
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_hold", {31'd0, cpu_hold}, 1);
    send_byte(8'h05, 0);
    send_byte(8'h01, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hEF, 0);
    wait_drain("start_abort");

    // Count byte 00 loads 256 words at 00..FF.
    words.delete();
    for (int i = 0; i < 256; i++) words.push_back({i[7:0], ~i[7:0]});
    run_session(8'h00, 8'h00, "full256");

    // Same short stream as the basic case, with random gaps below TIMEOUT.
    gmax  = 5;
    words = '{16'h0013, 16'hFFF3};
    run_session(8'hA0, 8'h02, "gaps_basic");
    words = '{16'h0102, 16'h0304, 16'h0506, 16'h0708,
              16'h090A, 16'h0B0C, 16'h0D0E, 16'h0F10};
    run_session(8'h10, 8'h08, "gaps_eight");
    gmax  = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: TIMEOUT, default 16'd50000, meaning max cycles waiting for a byte in any receive state before aborting.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  one-cycle pulse that begins a load session; honoured only in IDLE.
REQ-005 abort  in  1  terminates the session; ignored in IDLE.
REQ-006 byte_valid  in  1  upstream byte present.
REQ-007 byte_data  in  8  upstream byte.
REQ-008 byte_ready  out  1  loader accepts byte this cycle.
REQ-009 C12  out  1  RAM write enable to the 256x16 program/data RAM.
REQ-010 address  out  8  RAM word address.
REQ-011 wr_data  out  16  RAM write data.
REQ-012 cpu_hold  out  1  high while a session is active; holds the CPU off the RAM port.
REQ-013 done  out  1  one-cycle pulse on successful completion.
REQ-014 err  out  1  sticky timeout flag; cleared by rst or an accepted start.

Function
REQ-015 Byte transfer occurs on a rising edge with byte_valid=1 and byte_ready=1; byte_data need not be held afterwards.
REQ-016 Stream format: byte0 = start address, byte1 = word count N (0 means 256), then N words, high byte first.
REQ-017 States: IDLE, GET_ADDR, GET_CNT, GET_HI, GET_LO, WRITE, DONE.
REQ-018 IDLE -> GET_ADDR on start; err cleared on that edge.
REQ-019 GET_ADDR -> GET_CNT on transfer, latching the address pointer.
REQ-020 GET_CNT -> GET_HI on transfer, latching the remaining count (0 loads 256; 9-bit counter).
REQ-021 GET_HI -> GET_LO on transfer, latching the high byte; GET_LO -> WRITE on transfer, latching the low byte.
REQ-022 byte_ready is decoded from state: 1 in GET_ADDR, GET_CNT, GET_HI and GET_LO, 0 otherwise.
REQ-023 WRITE lasts exactly one cycle: C12=1, address=pointer, wr_data={hi,lo}, all stable for the full cycle so the RAM's falling-edge write captures them.
REQ-024 On leaving WRITE: pointer increments modulo 256 (0xFF wraps to 0x00), remaining decrements; next state is DONE if remaining becomes 0, else GET_HI.
REQ-025 DONE lasts one cycle with done=1, then IDLE.
REQ-026 C12=0 in every state except WRITE.
REQ-027 cpu_hold=1 in every state except IDLE.
REQ-028 address and wr_data hold their last values outside WRITE.
REQ-029 abort seen on a rising edge in any non-IDLE state -> IDLE next cycle, no done pulse, err unchanged.
REQ-030 abort seen at the edge ending WRITE: that write has already completed; no further writes occur.
REQ-031 start while not IDLE is ignored; start and abort together in IDLE -> start wins.
REQ-032 Timeout counter resets on every transfer and on entry to a receive state, and increments each cycle in a receive state without a transfer.
REQ-033 Counter reaching TIMEOUT -> IDLE next cycle and err=1.
REQ-034 A byte presented in a non-receive state is not consumed and stays pending upstream.

Reset
REQ-035 rst=1 asynchronously forces IDLE with C12=0, cpu_hold=0, done=0, err=0, byte_ready=0, address=0x00, wr_data=0x0000, internal counters 0.
REQ-036 Reset mid-session discards partial words; no write is issued after rst asserts.

Verification
REQ-037 start; bytes A0,02,00,13,FF,F3 -> C12 pulses at A0=0x0013, A1=0xFFF3; done one cycle after the second write; cpu_hold high from start through DONE.
REQ-038 start; bytes FF,02,12,34,56,78 -> writes FF=0x1234, 00=0x5678 (wrap).
REQ-039 start; count byte 00 with 512 data bytes -> exactly 256 C12 pulses at addresses 00..FF, then done.
REQ-040 byte_valid toggled randomly with gaps below TIMEOUT -> same write sequence as the back-to-back case, and no byte dropped or duplicated.
REQ-041 With TIMEOUT=16, stall 16 cycles after the high byte -> IDLE, err=1, no write; next start clears err.
REQ-042 abort in GET_LO and rst asserted in GET_HI -> no C12 pulse and no done pulse; IDLE with cpu_hold=0.
